// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : branch_predictor_pkg
// Purpose : Shared 2-bit counter type, counter encodings and update helper
//           for the fetch-side branch predictor.
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
package branch_predictor_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t STRONG_NT = 2'b00;
  localparam ctr_t WEAK_NT   = 2'b01;
  localparam ctr_t WEAK_T    = 2'b10;
  localparam ctr_t STRONG_T  = 2'b11;

  // Saturating step of a 2-bit counter toward the observed outcome.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    if (taken) begin
      nxt = (ctr == STRONG_T) ? STRONG_T : ctr_t'(ctr + 2'b01);
    end else begin
      nxt = (ctr == STRONG_NT) ? STRONG_NT : ctr_t'(ctr - 2'b01);
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb_entry_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : btb_entry_array
// Purpose : Direct-mapped storage of valid/tag/target/counter per entry.
//           One combinational read port for fetch lookup and one
//           synchronous read-modify-write port that applies the training
//           policy for a resolved branch.
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
module btb_entry_array
  import branch_predictor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = $clog2(ENTRIES),
  parameter int TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // lookup port
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0] rd_target,
  output logic                  rd_ctr_taken,
  // training port
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_target,
  input  logic                  wr_taken,
  input  logic                  wr_is_jump
);

  logic                  r_valid  [ENTRIES];
  ctr_t                  r_ctr    [ENTRIES];
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [ENTRIES];

  logic w_wr_hit;
  logic w_alloc;

  // Combinational read of the indexed entry; only the counter MSB matters.
  always_comb begin
    rd_valid     = r_valid[rd_idx];
    rd_tag       = r_tag[rd_idx];
    rd_target    = r_target[rd_idx];
    rd_ctr_taken = r_ctr[rd_idx][1];
  end

  // Classify the training access: train an existing entry or allocate one.
  always_comb begin
    w_wr_hit = r_valid[wr_idx] && (r_tag[wr_idx] == wr_tag);
    w_alloc  = wr_en && !w_wr_hit && wr_taken;
  end

  // Valid bits and counters: cleared by reset, trained on resolved branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= WEAK_NT;
      end
    end else if (wr_en) begin
      if (w_wr_hit) begin
        r_ctr[wr_idx] <= wr_is_jump ? STRONG_T : sat_update(r_ctr[wr_idx], wr_taken);
      end else if (w_alloc) begin
        r_valid[wr_idx] <= 1'b1;
        r_ctr[wr_idx]   <= wr_is_jump ? STRONG_T : WEAK_T;
      end
    end
  end

  // Tags and targets carry no reset; they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      if (w_alloc) begin
        r_tag[wr_idx]    <= wr_tag;
        r_target[wr_idx] <= wr_target;
      end else if (w_wr_hit && wr_taken) begin
        r_target[wr_idx] <= wr_target;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : branch_predictor
// Purpose : Fetch-side next-PC predictor (2-bit BHT + tagged BTB), trained
//           by execute-stage branch resolution. Generates the mispredict
//           flush/redirect and keeps saturating resolution statistics.
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_f,
  output logic                  pred_taken_f,
  output logic [DATA_WIDTH-1:0] pred_target_f,
  input  logic                  update_en,
  input  logic                  update_is_jump,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  pred_taken_e,
  input  logic [DATA_WIDTH-1:0] pred_target_e,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;

  logic [INDEX_BITS-1:0] w_idx_f;
  logic [TAG_BITS-1:0]   w_tag_f;
  logic [INDEX_BITS-1:0] w_idx_u;
  logic [TAG_BITS-1:0]   w_tag_u;
  logic                  w_rd_valid;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [DATA_WIDTH-1:0] w_rd_target;
  logic                  w_rd_ctr_taken;
  logic                  w_hit_f;

  // Split both PCs into index and tag; pc[1:0] takes no part in lookup.
  always_comb begin
    w_idx_f = pc_f[INDEX_BITS+1:2];
    w_tag_f = pc_f[DATA_WIDTH-1:INDEX_BITS+2];
    w_idx_u = update_pc[INDEX_BITS+1:2];
    w_tag_u = update_pc[DATA_WIDTH-1:INDEX_BITS+2];
  end

  btb_entry_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (ENTRIES),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_idx       (w_idx_f),
    .rd_valid     (w_rd_valid),
    .rd_tag       (w_rd_tag),
    .rd_target    (w_rd_target),
    .rd_ctr_taken (w_rd_ctr_taken),
    .wr_en        (update_en),
    .wr_idx       (w_idx_u),
    .wr_tag       (w_tag_u),
    .wr_target    (update_target),
    .wr_taken     (update_taken),
    .wr_is_jump   (update_is_jump)
  );

  // Zero-latency prediction; forced not-taken while reset is held because
  // the table only clears at the reset edge.
  always_comb begin
    w_hit_f       = w_rd_valid && (w_rd_tag == w_tag_f);
    pred_taken_f  = !rst && w_hit_f && w_rd_ctr_taken;
    pred_target_f = pred_taken_f ? w_rd_target : pc_f + DATA_WIDTH'(4);
  end

  // Resolution check against what fetch predicted for this instruction.
  always_comb begin
    mispredict  = update_en && ((update_taken != pred_taken_e) ||
                                (update_taken && (update_target != pred_target_e)));
    redirect_pc = update_taken ? update_target : update_pc + DATA_WIDTH'(4);
  end

  // Saturating statistics; an update coincident with reset is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_en && (branch_count != 32'hFFFF_FFFF)) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart of the execute-stage branch resolution logic.
- The execute stage reports each resolved control-flow outcome (the pc_sel decision plus the computed target). This block learns from those outcomes and predicts the next PC for the fetch stage.
- Structure: direct-mapped BHT of 2-bit saturating counters plus a tagged BTB.
- Also produces the mispredict/redirect signal that flushes fetch and decode.

Parameters:
- DATA_WIDTH, 32, address/data width.
- ENTRIES, 16, number of BHT/BTB entries; must be a power of 2, minimum 2.
- INDEX_BITS, $clog2(ENTRIES), derived; do not override.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- pc_f  input  DATA_WIDTH  fetch PC to predict.
- pred_taken_f  output  1  prediction for pc_f is taken.
- pred_target_f  output  DATA_WIDTH  predicted next PC for pc_f.
- update_en  input  1  execute stage holds a resolved branch/jump this cycle.
- update_is_jump  input  1  resolved instruction is jal/jalr (unconditional).
- update_pc  input  DATA_WIDTH  PC of the resolved instruction.
- update_taken  input  1  actual outcome (pc_sel from resolution).
- update_target  input  DATA_WIDTH  actual taken target.
- pred_taken_e  input  1  prediction made for this instruction, piped down from fetch.
- pred_target_e  input  DATA_WIDTH  predicted next PC, piped down from fetch.
- mispredict  output  1  flush fetch/decode and redirect.
- redirect_pc  output  DATA_WIDTH  correct next PC when mispredict is high.
- branch_count  output  32  resolved updates since reset.
- mispredict_count  output  32  mispredicts since reset.

Behaviour:
- Index is pc[INDEX_BITS+1:2]. Tag is pc[DATA_WIDTH-1:INDEX_BITS+2].
- Lookup is combinational with zero latency:
  - hit = valid[idx] & (tag[idx] == tag(pc_f)).
  - pred_taken_f = hit & ctr[idx][1].
  - pred_target_f = pred_taken_f ? btb_target[idx] : pc_f + 4.
- mispredict is combinational: update_en & ((update_taken != pred_taken_e) | (update_taken & (update_target != pred_target_e))).
- redirect_pc = update_taken ? update_target : update_pc + 4. It is meaningful only when mispredict = 1.
- Table update happens on the clk edge when update_en = 1 and rst = 0.
  - Miss and not taken: no allocation, no state change.
  - Miss and taken: allocate the entry.
    - valid = 1, tag and target written.
    - ctr = 2'b11 if update_is_jump, else 2'b10 (weakly taken).
    - A conflicting entry is overwritten.
  - Hit:
    - Taken: ctr saturating increment (max 2'b11), target overwritten with update_target.
    - Not taken: ctr saturating decrement (min 2'b00), target kept.
    - update_is_jump forces ctr = 2'b11.
- Same-index lookup and update in one cycle: the lookup sees pre-update state. There is no bypass.
- Statistics counters:
  - branch_count increments on every update_en.
  - mispredict_count increments when mispredict = 1.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- Reset (synchronous, active-high) clears all table state and counters:
  - All valid = 0, all ctr = 2'b01, branch_count = 0, mispredict_count = 0.
  - BTB targets and tags are don't-care.
  - During reset: pred_taken_f = 0, pred_target_f = pc_f + 4.
  - mispredict still follows its combinational equation, so the upstream pipeline must hold update_en = 0 during rst.
  - An update coincident with rst is discarded.
- Misaligned pc[1:0] bits are ignored.

Decomposition:
- Shared package defines:
  - ctr_t (2-bit counter type).
  - Counter constants: STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11.
  - Function sat_update(ctr_t, taken) returning the next counter value.
- One sub-module: btb_entry_array, holding the valid/tag/target/ctr storage.
  - One combinational read port and one synchronous write port.
  - Synchronous clear on rst.
- Prediction, mispredict and statistics logic stay in branch_predictor.

Test Plan:
- Reset, then pc_f = 0x100 → pred_taken_f = 0, pred_target_f = 0x104, both counters 0.
- Update pc 0x100, taken, target 0x80, pred_taken_e = 0 → mispredict = 1, redirect_pc = 0x80. Next cycle pc_f = 0x100 → pred_taken_f = 1, pred_target_f = 0x80, ctr = 2'b10.
- Same branch resolved not-taken twice (predictions from fetch piped in) → ctr goes 2'b10 → 2'b01 → 2'b00. pred_taken_f = 0 after the first update. Second update has mispredict = 0. redirect_pc = 0x104 on the first.
- Aliasing with ENTRIES = 16: entry at 0x100 installed, then 0x140 (same index) resolved taken to 0x200 → lookup 0x100 misses (0x104), lookup 0x140 hits → 0x200.
- jalr at 0x20 with pred_target_e = 0x300, actual target 0x340, pred_taken_e = 1 → mispredict = 1 (target mismatch), redirect_pc = 0x340, BTB target updated, ctr = 2'b11.
- Update and lookup of the same pc in the same cycle → lookup returns pre-update prediction. Assert rst mid-stream → all lookups revert to pc + 4 and counters return to 0 on the next cycle.
